cfr_ipif_arbiter: RTL
=====================

// Module: cfr_ipif_arbiter
// PURPOSE
// Shares one CFR IPIF slave port (e.g. the CFR register mux) among NUM_MASTER IPIF masters
// (AXI-lite bridge, config sequencer, debug). Captures single-cycle requests, grants round-robin,
// issues one transaction at a time and routes the ack back. A watchdog completes hung accesses.
// PARAMETERS
// NUM_MASTER      2             number of IPIF masters (>=2)
// ADDR_WIDTH      15            IPIF address width
// DATA_WIDTH      32            IPIF data width
// TIMEOUT         255           cycles from s_*_req to forced completion (>=2)
// TIMEOUT_DATA    32'hDEADBEEF  rd_data returned on read timeout
// PORTS
// clk              in   1                       clock
// rst              in   1                       synchronous reset, active-high
// m_wr_addr[NM]    in   ADDR_WIDTH              master write address
// m_wr_req[NM]     in   1                       master write request, 1-cycle pulse
// m_wr_data[NM]    in   DATA_WIDTH              master write data
// m_wr_ack[NM]     out  1                       master write ack, 1-cycle pulse
// m_rd_addr[NM]    in   ADDR_WIDTH              master read address
// m_rd_req[NM]     in   1                       master read request, 1-cycle pulse
// m_rd_data[NM]    out  DATA_WIDTH              master read data, valid with m_rd_ack
// m_rd_ack[NM]     out  1                       master read ack, 1-cycle pulse
// s_wr_addr/s_wr_data out ADDR_WIDTH/DATA_WIDTH slave write address/data
// s_wr_req         out  1                       slave write request pulse
// s_wr_ack         in   1                       slave write ack
// s_rd_addr        out  ADDR_WIDTH              slave read address
// s_rd_req         out  1                       slave read request pulse
// s_rd_data        in   DATA_WIDTH              slave read data, valid with s_rd_ack
// s_rd_ack         in   1                       slave read ack
// timeout_err      out  1                       1-cycle pulse when a transaction times out
// busy             out  1                       high while a slave transaction is outstanding
// BEHAVIOUR
// - Reset: all outputs 0, pending flags clear, state IDLE, RR pointer = master 0.
// - Capture: m_*_req at cycle T sets per-master wr/rd pending flag and latches addr/data at T+1.
//   Req on an already-pending slot is a protocol violation: ignored, first capture kept.
// - Arbitration (IDLE, any pending): round-robin from pointer; within a master, write before read.
//   Grant registered: s_*_req pulse + addr/data next cycle (req at T -> s_req at T+2 when idle).
//   Pointer = granted master + 1 (mod NUM_MASTER); state -> WAIT_WR or WAIT_RD.
// - s_*_addr/s_*_data hold last granted value until next grant.
// - WAIT_x: on matching s_x_ack at A: m_x_ack (and m_rd_data <= s_rd_data) to granted master at A+1,
//   pending cleared, -> IDLE; next grant's s_req earliest at A+2. Non-matching acks ignored.
// - Timeout: counter loads 0 at s_req, increments per WAIT cycle; at TIMEOUT without ack: complete
//   as above with m_rd_data = TIMEOUT_DATA (reads), timeout_err pulse, -> IDLE.
//   Ack arriving same cycle as timeout expiry: ack wins, no timeout_err.
// - Acks received in IDLE (late slave ack) are dropped; never forwarded.
// - New requests captured during WAIT are held pending, never lost; m_*_ack never to non-granted master.
// - busy = (state != IDLE).
// - Reset mid-transaction: transaction abandoned, no ack issued, all pending requests discarded.
// TESTING
// - Single write m0 addr 0x0123 data 0xA5A5A5A5, slave acks 1 cycle after s_wr_req -> s_wr_req at T+2,
//   m_wr_ack[0] once, no ack on m1.
// - m0 and m1 reads same cycle, then repeat -> grant order m0,m1 then m1,m0? no: m0,m1,m0,m1
//   (RR pointer); m_rd_data matches per-master slave data.
// - m0 write+read same cycle -> write issued first, read after write ack.
// - Slave never acks read, TIMEOUT=8 -> m_rd_ack 9 cycles after s_rd_req, data 0xDEADBEEF,
//   timeout_err pulse; late s_rd_ack later dropped.
// - rst asserted in WAIT_RD with m1 pending -> all outputs 0, no acks, next request behaves as fresh.

Source files
------------

// File: rtl/cfr_ipif_arbiter.sv
// Round-robin arbiter sharing one CFR IPIF slave port among NUM_MASTER IPIF masters,
// with per-master request capture, one outstanding slave transaction and a completion watchdog.
module cfr_ipif_arbiter #(
   parameter int unsigned NUM_MASTER = 2,
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] m_wr_addr [NUM_MASTER],
   input  logic [NUM_MASTER-1:0] m_wr_req,
   input  logic [DATA_WIDTH-1:0] m_wr_data [NUM_MASTER],
   output logic [NUM_MASTER-1:0] m_wr_ack,
   input  logic [ADDR_WIDTH-1:0] m_rd_addr [NUM_MASTER],
   input  logic [NUM_MASTER-1:0] m_rd_req,
   output logic [DATA_WIDTH-1:0] m_rd_data [NUM_MASTER],
   output logic [NUM_MASTER-1:0] m_rd_ack,
   output logic [ADDR_WIDTH-1:0] s_wr_addr,
   output logic [DATA_WIDTH-1:0] s_wr_data,
   output logic                  s_wr_req,
   input  logic                  s_wr_ack,
   output logic [ADDR_WIDTH-1:0] s_rd_addr,
   output logic                  s_rd_req,
   input  logic [DATA_WIDTH-1:0] s_rd_data,
   input  logic                  s_rd_ack,
   output logic                  timeout_err,
   output logic                  busy
);

   localparam int unsigned PW = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT_WR, WAIT_RD} state_t;

   state_t                  state, state_nxt;
   logic [NUM_MASTER-1:0]   wr_pend, rd_pend;
   logic [ADDR_WIDTH-1:0]   wr_addr_q [NUM_MASTER];
   logic [ADDR_WIDTH-1:0]   rd_addr_q [NUM_MASTER];
   logic [DATA_WIDTH-1:0]   wr_data_q [NUM_MASTER];
   logic [PW-1:0]           ptr, gidx, sel_idx;
   logic [CW-1:0]           cnt;
   logic                    sel_vld, sel_wr, done, expired;

   assign busy = (state != IDLE);

   always_comb begin
      int unsigned idx;
      idx       = 0;
      state_nxt = state;
      sel_vld   = 1'b0;
      sel_idx   = '0;
      sel_wr    = 1'b0;
      done      = 1'b0;
      expired   = 1'b0;
      unique case (state)
         IDLE: begin
            // First pending master at or after the pointer; a master's write beats its read.
            for (int unsigned i = 0; i < NUM_MASTER; i++) begin
               idx = 32'(ptr) + i;
               if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
               if (!sel_vld && (wr_pend[idx] || rd_pend[idx])) begin
                  sel_vld = 1'b1;
                  sel_idx = PW'(idx);
                  sel_wr  = wr_pend[idx];
               end
            end
            if (sel_vld) state_nxt = sel_wr ? WAIT_WR : WAIT_RD;
         end
         WAIT_WR, WAIT_RD: begin
            if ((state == WAIT_WR) ? s_wr_ack : s_rd_ack) begin
               done = 1'b1;
            end else if (cnt == CW'(TIMEOUT)) begin
               done    = 1'b1;
               expired = 1'b1;
            end
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_pend     <= '0;
         rd_pend     <= '0;
         ptr         <= '0;
         gidx        <= '0;
         cnt         <= '0;
         s_wr_addr   <= '0;
         s_wr_data   <= '0;
         s_wr_req    <= 1'b0;
         s_rd_addr   <= '0;
         s_rd_req    <= 1'b0;
         m_wr_ack    <= '0;
         m_rd_ack    <= '0;
         timeout_err <= 1'b0;
         for (int unsigned m = 0; m < NUM_MASTER; m++) begin
            wr_addr_q[m] <= '0;
            rd_addr_q[m] <= '0;
            wr_data_q[m] <= '0;
            m_rd_data[m] <= '0;
         end
      end else begin
         state       <= state_nxt;
         s_wr_req    <= 1'b0;
         s_rd_req    <= 1'b0;
         m_wr_ack    <= '0;
         m_rd_ack    <= '0;
         timeout_err <= 1'b0;
         if (state != IDLE) cnt <= cnt + 1'b1;

         // A request on a slot that is still pending is dropped; the first capture stands.
         for (int unsigned m = 0; m < NUM_MASTER; m++) begin
            if (m_wr_req[m] && !wr_pend[m]) begin
               wr_pend[m]   <= 1'b1;
               wr_addr_q[m] <= m_wr_addr[m];
               wr_data_q[m] <= m_wr_data[m];
            end
            if (m_rd_req[m] && !rd_pend[m]) begin
               rd_pend[m]   <= 1'b1;
               rd_addr_q[m] <= m_rd_addr[m];
            end
         end

         if (sel_vld) begin
            gidx <= sel_idx;
            ptr  <= (sel_idx == PW'(NUM_MASTER - 1)) ? '0 : sel_idx + 1'b1;
            cnt  <= '0;
            if (sel_wr) begin
               s_wr_req  <= 1'b1;
               s_wr_addr <= wr_addr_q[sel_idx];
               s_wr_data <= wr_data_q[sel_idx];
            end else begin
               s_rd_req  <= 1'b1;
               s_rd_addr <= rd_addr_q[sel_idx];
            end
         end

         if (done) begin
            timeout_err <= expired;
            if (state == WAIT_WR) begin
               m_wr_ack[gidx] <= 1'b1;
               wr_pend[gidx]  <= 1'b0;
            end else begin
               m_rd_ack[gidx]  <= 1'b1;
               m_rd_data[gidx] <= expired ? TIMEOUT_DATA : s_rd_data;
               rd_pend[gidx]   <= 1'b0;
            end
         end
      end
   end

endmodule
